// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared definitions for the data-memory responder slice: word width, the
// width of the wait-state counter and the responder FSM state encoding.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_pkg;

    localparam int WORD_W = 32;
    // Wide enough for WAIT_STATES in 0..15
    localparam int WS_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/data_mem_responder_if.sv
// -----------------------------------------------------------------------------
// data_mem_responder_if
// Request/response bus between a CPU load/store unit (master) and the data
// memory responder (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : byte address
//   req_wdata           : store data
//   req_we / req_re     : MemWrite / MemRead
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : load data
//   rsp_err             : response error flag
// -----------------------------------------------------------------------------
interface data_mem_responder_if;
    import dmem_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic [WORD_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              req_we;
    logic              req_re;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [WORD_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_addr, req_wdata, req_we, req_re, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wdata, req_we, req_re, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );

endinterface

// File: rtl/data_mem_responder_array.sv
// -----------------------------------------------------------------------------
// dmem_array
// Word-addressed storage: clocked write, combinational read, contents are
// never reset.
//   clk   : clock
//   we    : write enable (sampled on rising edge)
//   idx   : word index for both write and read
//   wdata : write data
//   rdata : combinational read data at idx
// -----------------------------------------------------------------------------
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = 6
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     idx,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[idx] <= wdata;
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Single-outstanding data memory responder with a fixed, programmable
// response latency. Requests are accepted in IDLE, held in WAIT for
// WAIT_STATES cycles, then answered in RESP until the CPU takes the response.
// Writes commit and reads sample storage only on entry to RESP.
//   clk   : clock
//   reset : synchronous, active-low reset
//   bus   : data_mem_responder_if.slave request/response bus
// Optional feature: define DMEM_MISALIGN_CHECK_EN to flag accesses whose
// address is not word aligned (rsp_err=1, no write, rsp_rdata=0).
// -----------------------------------------------------------------------------
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int WAIT_STATES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);

    localparam int AW = $clog2(DEPTH_WORDS);
    // Counter counts down to zero, so WAIT lasts WAIT_STATES cycles
    localparam logic [WS_W-1:0] WS_LOAD = (WAIT_STATES == 0) ? '0 : WS_W'(WAIT_STATES - 1);

    state_t            state;
    logic [WS_W-1:0]   cnt;

    logic [AW-1:0]     idx_q;
    logic [WORD_W-1:0] wdata_q;
    logic              we_q;
    logic              re_q;
    logic              mis_q;

    logic              accept;
    logic              mis_in;
    logic              unused_addr;

    logic              cmt_fire;
    logic [AW-1:0]     cmt_idx;
    logic [WORD_W-1:0] cmt_wdata;
    logic              cmt_we;
    logic              cmt_re;
    logic              cmt_mis;
    logic [WORD_W-1:0] rdata_next;

    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;

    assign accept = (state == IDLE) && bus.req_valid && bus.req_ready;

`ifdef DMEM_MISALIGN_CHECK_EN
    assign mis_in = |bus.req_addr[1:0];
`else
    assign mis_in = 1'b0;
`endif

    // Address bits outside the word index never affect behaviour
    assign unused_addr = ^{bus.req_addr[WORD_W-1:AW+2], bus.req_addr[1:0]};

    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q   <= bus.req_addr[AW+1:2];
            wdata_q <= bus.req_wdata;
            we_q    <= bus.req_we;
            re_q    <= bus.req_re;
            mis_q   <= mis_in;
        end
    end

    // With zero wait states the commit happens on the accept edge itself,
    // so the commit path takes the live request instead of the latched copy.
    always_comb begin
        cmt_fire  = (state == WAIT) && (cnt == '0);
        cmt_idx   = idx_q;
        cmt_wdata = wdata_q;
        cmt_we    = we_q;
        cmt_re    = re_q;
        cmt_mis   = mis_q;
        if (WAIT_STATES == 0) begin
            cmt_fire  = accept;
            cmt_idx   = bus.req_addr[AW+1:2];
            cmt_wdata = bus.req_wdata;
            cmt_we    = bus.req_we;
            cmt_re    = bus.req_re;
            cmt_mis   = mis_in;
        end
    end

    // we=1 always wins over re=1; no-ops and flagged accesses return zero
    assign rdata_next = (cmt_re && !cmt_we && !cmt_mis) ? mem_rdata : '0;
    // Gated by reset so a reset edge coinciding with commit drops the write
    assign mem_we     = reset && cmt_fire && cmt_we && !cmt_mis;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (cmt_idx),
        .wdata (cmt_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (accept) begin
                        bus.req_ready <= 1'b0;
                        if (WAIT_STATES == 0) begin
                            state         <= RESP;
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_rdata <= rdata_next;
                            bus.rsp_err   <= cmt_mis;
                        end else begin
                            state <= WAIT;
                            cnt   <= WS_LOAD;
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state         <= RESP;
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_rdata <= rdata_next;
                        bus.rsp_err   <= cmt_mis;
                    end else begin
                        cnt <= cnt - WS_W'(1);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        state         <= IDLE;
                        bus.rsp_valid <= 1'b0;
                        bus.req_ready <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench for data_mem_responder (DEPTH_WORDS=64, WAIT_STATES=2).
// Each scenario task drives its own transactions and compares the observed
// response against hand-computed values.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;
    import dmem_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    data_mem_responder_if bus ();

    data_mem_responder #(
        .DEPTH_WORDS (64),
        .WAIT_STATES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time %0t", $time);
        $fatal(1);
    end

    // One complete transaction. cyc is the number of rising edges from the
    // accept edge up to and including the first edge at which rsp_valid is 1.
    task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                          input logic we, input logic re, input int hold,
                          output logic [31:0] rdata, output logic err,
                          output int cyc, output logic stable,
                          output logic rdy_low, output logic idle,
                          output logic ok);
        int n;
        ok = 1'b1; stable = 1'b1; rdy_low = 1'b1; idle = 1'b0;
        cyc = 0; rdata = '0; err = 1'b0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_we    = we;
        bus.req_re    = re;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.req_ready) begin
            ok = 1'b0;
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        cyc = 1;
        while (!bus.rsp_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (!bus.rsp_valid) begin
            ok = 1'b0;
            return;
        end
        rdata = bus.rsp_rdata;
        err   = bus.rsp_err;
        if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
        repeat (hold) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.rsp_err !== err)
                stable = 1'b0;
            if (bus.req_ready !== 1'b0) rdy_low = 1'b0;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        idle = (bus.req_ready === 1'b1) && (bus.rsp_valid === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b expected 0", bus.req_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
        total++; if (bus.rsp_rdata !== 32'h0) $display("FAIL reset_rsp_rdata: got %h expected 00000000", bus.rsp_rdata); else passed++;
        total++; if (bus.rsp_err !== 1'b0) $display("FAIL reset_rsp_err: got %b expected 0", bus.rsp_err); else passed++;
        reset = 1'b1;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b1) $display("FAIL reset_release_ready: got %b expected 1", bus.req_ready); else passed++;
    endtask

    task automatic test_write_read();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (ok !== 1'b1) $display("FAIL wr_handshake: timed out (ok=%b) expected 1", ok); else passed++;
        total++; if (cyc != 3) $display("FAIL wr_latency: got %0d expected 3", cyc); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL wr_rdata: got %h expected 00000000", rd); else passed++;
        do_txn(32'h10, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (ok !== 1'b1) $display("FAIL rd_handshake: timed out (ok=%b) expected 1", ok); else passed++;
        total++; if (cyc != 3) $display("FAIL rd_latency: got %0d expected 3", cyc); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_rdata: got %h expected deadbeef", rd); else passed++;
        total++; if (er !== 1'b0) $display("FAIL rd_err: got %b expected 0", er); else passed++;
        total++; if (id !== 1'b1) $display("FAIL rd_idle_after: got %b expected 1", id); else passed++;
    endtask

    task automatic test_backpressure();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h60, 32'h0000ABCD, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        do_txn(32'h60, 32'h0, 1'b0, 1'b1, 5, rd, er, cyc, st, rl, id, ok);
        total++; if (ok !== 1'b1) $display("FAIL bp_handshake: timed out (ok=%b) expected 1", ok); else passed++;
        total++; if (rd !== 32'h0000ABCD) $display("FAIL bp_rdata: got %h expected 0000abcd", rd); else passed++;
        total++; if (st !== 1'b1) $display("FAIL bp_stable: got %b expected 1", st); else passed++;
        total++; if (rl !== 1'b1) $display("FAIL bp_req_ready_low: got %b expected 1", rl); else passed++;
        total++; if (id !== 1'b1) $display("FAIL bp_idle_next: got %b expected 1", id); else passed++;
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h104, 32'h12345678, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        do_txn(32'h004, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'h12345678) $display("FAIL wrap_rdata: got %h expected 12345678", rd); else passed++;
    endtask

    task automatic test_we_re();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h20, 32'hA5A5A5A5, 1'b1, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'h0) $display("FAIL wer_rdata: got %h expected 00000000", rd); else passed++;
        do_txn(32'h20, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'hA5A5A5A5) $display("FAIL wer_readback: got %h expected a5a5a5a5", rd); else passed++;
    endtask

    task automatic test_noop();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h30, 32'h00000077, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        do_txn(32'h30, 32'h00000099, 1'b0, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (ok !== 1'b1) $display("FAIL noop_handshake: timed out (ok=%b) expected 1", ok); else passed++;
        total++; if (rd !== 32'h0) $display("FAIL noop_rdata: got %h expected 00000000", rd); else passed++;
        do_txn(32'h30, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'h00000077) $display("FAIL noop_no_write: got %h expected 00000077", rd); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        for (int i = 0; i < 3; i++) begin
            logic [31:0] val;
            val = 32'h1111_0000 + 32'(i * 3 + 1);
            do_txn(32'h40, val, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
            do_txn(32'h40, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
            total++; if (rd !== val) $display("FAIL b2b_raw_%0d: got %h expected %h", i, rd, val); else passed++;
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h08, 32'hCAFE0008, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h08;
        bus.req_wdata = 32'h00000001;
        bus.req_we    = 1'b1;
        bus.req_re    = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        total++; if (bus.req_ready !== 1'b0) $display("FAIL abort_req_ready: got %b expected 0", bus.req_ready); else passed++;
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid: got %b expected 0", bus.rsp_valid); else passed++;
        total++; if (bus.rsp_rdata !== 32'h0) $display("FAIL abort_rsp_rdata: got %h expected 00000000", bus.rsp_rdata); else passed++;
        @(negedge clk);
        total++; if (bus.rsp_valid !== 1'b0) $display("FAIL abort_rsp_valid_hold: got %b expected 0", bus.rsp_valid); else passed++;
        reset = 1'b1;
        do_txn(32'h08, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'hCAFE0008) $display("FAIL abort_no_commit: got %h expected cafe0008", rd); else passed++;
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er, st, rl, id, ok; int cyc;
        do_txn(32'h08, 32'h11111111, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        do_txn(32'h0A, 32'h22222222, 1'b1, 1'b0, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (cyc != 3) $display("FAIL mis_latency: got %0d expected 3", cyc); else passed++;
`ifdef DMEM_MISALIGN_CHECK_EN
        total++; if (er !== 1'b1) $display("FAIL mis_err: got %b expected 1", er); else passed++;
        do_txn(32'h08, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'h11111111) $display("FAIL mis_word_kept: got %h expected 11111111", rd); else passed++;
`else
        total++; if (er !== 1'b0) $display("FAIL mis_err: got %b expected 0", er); else passed++;
        do_txn(32'h08, 32'h0, 1'b0, 1'b1, 0, rd, er, cyc, st, rl, id, ok);
        total++; if (rd !== 32'h22222222) $display("FAIL mis_word_written: got %h expected 22222222", rd); else passed++;
`endif
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_we    = 1'b0;
        bus.req_re    = 1'b0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_wrap();
        test_we_re();
        test_noop();
        test_back_to_back();
        test_reset_abort();
        test_misalign();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
